// File: rtl/answer_bcd_conv_if.sv
// rtl/answer_bcd_conv_if.sv - start/answer request and BCD result bundle
interface answer_bcd_conv_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [WIDTH-1:0]      answer;
    logic                  busy;
    logic                  valid;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     blank;
    logic                  neg;
    logic                  ovf;

    modport master (
        output start, answer,
        input  busy, valid, digits, blank, neg, ovf
    );

    modport slave (
        input  start, answer,
        output busy, valid, digits, blank, neg, ovf
    );
endinterface

// File: rtl/answer_bcd_conv.sv
// rtl/answer_bcd_conv.sv - signed binary answer to sign/magnitude BCD digits via double dabble
module answer_bcd_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    answer_bcd_conv_if.slave   bus
);
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Leading-zero blanking: walk down from the top digit while everything seen so far is zero.
    function automatic logic [DIGITS-1:0] calc_blank(input logic [4*DIGITS-1:0] d);
        logic              lead;
        logic [DIGITS-1:0] b;
        lead = 1'b1;
        b    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead & (d[4*i +: 4] == 4'd0);
            b[i] = lead;
        end
        return b;
    endfunction

    localparam int          CW    = $clog2(WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    ans_q;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] scratch;
    logic [CW-1:0]       cnt;
    logic                neg_q;
    logic                ovf_q;

    logic                busy_r;
    logic                valid_r;
    logic [4*DIGITS-1:0] digits_r;
    logic [DIGITS-1:0]   blank_r;
    logic                neg_r;
    logic                ovf_r;

    logic [WIDTH-1:0]    abs_val;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nx;

    // Two's-complement magnitude of the captured answer; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        abs_val = ans_q;
        if (ans_q[WIDTH-1]) begin
            abs_val = ~ans_q + WIDTH'(1);
        end
    end

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_nx = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
    end

    // Conversion FSM; result registers only change when DONE is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ans_q    <= '0;
            mag      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            digits_r <= '0;
            blank_r  <= '0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (bus.start) begin
                        ans_q  <= bus.answer;
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    mag     <= abs_val;
                    neg_q   <= ans_q[WIDTH-1];
                    ovf_q   <= (64'(abs_val) >= LIMIT);
                    scratch <= '0;
                    cnt     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    // The range verdict from LOAD is acted on here, so an overflow still
                    // reports two cycles after start and skips the shift loop entirely.
                    if (ovf_q) begin
                        digits_r <= {DIGITS{4'hE}};
                        blank_r  <= '0;
                        neg_r    <= neg_q;
                        ovf_r    <= 1'b1;
                        valid_r  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        scratch <= scratch_nx;
                        mag     <= mag << 1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            digits_r <= scratch_nx;
                            blank_r  <= calc_blank(scratch_nx);
                            neg_r    <= neg_q;
                            ovf_r    <= 1'b0;
                            valid_r  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.valid  = valid_r;
    assign bus.digits = digits_r;
    assign bus.blank  = blank_r;
    assign bus.neg    = neg_r;
    assign bus.ovf    = ovf_r;
endmodule

// File: doc/answer_bcd_conv.md
ANSWER_BCD_CONV -- requirements
Module: answer_bcd_conv

Interface
REQ-001 Parameter: WIDTH, 32, bit width of the signed two's-complement answer.
REQ-002 Parameter: DIGITS, 8, number of BCD digits produced (one per seven-segment display).
REQ-003 clk  input  1  system clock (50 MHz domain, same as the postfix solver).
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse, driven by the solver's done strobe; requests conversion of answer.
REQ-006 answer  input  WIDTH  signed result from the postfix solver; sampled on the edge where start is accepted.
REQ-007 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-008 valid  output  1  one-cycle pulse when new digit/flag outputs are presented.
REQ-009 digits  output  4*DIGITS  BCD digits; digit i in bits [4i+3:4i]; digit 0 is least significant.
REQ-010 blank  output  DIGITS  bit i high when digit i is a leading zero; bit 0 is never set.
REQ-011 neg  output  1  answer was negative.
REQ-012 ovf  output  1  magnitude was not representable in DIGITS decimal digits.

Function
REQ-013 The FSM shall have the states IDLE, LOAD, SHIFT and DONE.
REQ-014 IDLE: start=1 shall capture answer into an internal register and move to LOAD; start shall be ignored in every other state.
REQ-015 LOAD: neg shall be computed as answer[WIDTH-1]; magnitude shall be the two's-complement absolute value held as WIDTH-bit unsigned (0x8000_0000 -> 2147483648).
REQ-016 LOAD: if magnitude >= 10^DIGITS, the FSM shall go to DONE with ovf=1, every digit = 4'hE, blank = 0; otherwise it shall clear the BCD scratch register, set the bit counter to 0 and go to SHIFT.
REQ-017 SHIFT: in each cycle, every scratch BCD digit >= 5 shall have 3 added, then {scratch, magnitude} shall be shifted left by one; this is a double-dabble step.
REQ-018 SHIFT shall run exactly WIDTH cycles; after the step with counter = WIDTH-1 the FSM shall go to DONE.
REQ-019 On entry to DONE the output registers digits, blank, neg and ovf shall be loaded and valid shall be asserted.
REQ-020 DONE shall last one cycle, then go to IDLE; valid shall be high only in that cycle.
REQ-021 Latency: with start sampled at edge k, valid shall rise at edge k+33 for a normal conversion and at edge k+2 for overflow.
REQ-022 digits, blank, neg and ovf shall hold their previous values throughout a conversion and change only on entry to DONE.
REQ-023 blank shall be computed from the final digits, scanning from digit DIGITS-1 downward; a digit is blanked while it and all higher digits are 0.
REQ-024 answer = 0 shall give digits all 0 and blank = 8'hFE; a negative zero cannot occur.
REQ-025 The counter shall be ceil(log2(WIDTH+1)) bits and shall never wrap during SHIFT.

Reset
REQ-026 With reset_n low, the block shall be in IDLE with busy=0, valid=0, digits=0, blank=0, neg=0 and ovf=0, applied asynchronously.
REQ-027 Reset asserted mid-conversion shall abort the conversion; no valid shall follow it.
REQ-028 After reset release, the first start in IDLE shall be accepted normally.

Verification
REQ-029 start with answer=1234 (0x0000_04D2) -> valid at k+33, digits=0x0000_1234, blank=8'hF0, neg=0, ovf=0, busy high k+1..k+33.
REQ-030 start with answer=-56 (0xFFFF_FFC8) -> digits=0x0000_0056, blank=8'hFC, neg=1, ovf=0.
REQ-031 start with answer=99_999_999 -> digits=0x9999_9999, blank=0, ovf=0; a following start with answer=100_000_000 -> valid at k+2, ovf=1, digits=0xEEEE_EEEE.
REQ-032 start with answer=0x8000_0000 -> ovf=1, neg=1, digits=0xEEEE_EEEE.
REQ-033 start with answer=1234, then start with answer=7 at k+10 -> the second start is ignored, a single valid at k+33 with digits=0x0000_1234, and outputs unchanged between k and k+33.
REQ-034 reset_n pulsed low at k+15 during a conversion -> all outputs 0 immediately, no valid; after release, start with answer=7 -> digits=0x0000_0007, blank=8'hFE.
